lightpipe_framer_p: RTL

Parametrised successor to the fixed 8×24-bit lightpipe transmitter. It serialises CHANNELS samples of WIDTH bits plus USER_BITS user bits into one framed, optionally NRZI-coded bitstream at one bit per `mclk`. A frame is launched on each rising edge of `wordclock`. The block sits between the sample-word source and the optical/serial output pin, and is the transmit counterpart of `lightpipe_recv`.

---
 rtl/lightpipe_framer_p.sv | 106 ++++++++++
 1 files changed

// File: rtl/lightpipe_framer_p.sv
// Lightpipe transmitter: serialises CHANNELS x WIDTH samples plus user bits into
// a sync-prefixed, nibble-separated frame, one bit per mclk, optionally NRZI coded.
//
// state | meaning
// IDLE  | no frame in flight; NRZI line holds its level, raw line sits at 0
// SEND  | counter walks frame bits 0..L-1 from the shadow copy
module lightpipe_framer_p #(
    parameter int CHANNELS   = 8,
    parameter int WIDTH      = 24,
    parameter int USER_BITS  = 4,
    parameter int SYNC_ZEROS = 10,
    parameter int NRZI       = 1
) (
    input  logic                      mclk,
    input  logic                      rst,
    input  logic                      wordclock,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [USER_BITS-1:0]      user,
    output logic                      lightpipe,
    output logic                      busy,
    output logic                      frame_start,
    output logic                      overrun
);

    localparam int PAY = USER_BITS + CHANNELS*WIDTH;
    localparam int L   = SYNC_ZEROS + 1 + (5*PAY)/4;
    localparam int CW  = $clog2(L);
    localparam logic [CW-1:0] LAST = CW'(L-1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PAY-1:0]  shadow;
    logic [PAY-1:0]  payload_in;
    logic            wc_d;
    logic            edge_w;
    logic            accept;
    logic            nbit;

    // Payload is laid out MSB-first in transmit order: user, then channel 0..N-1.
    assign payload_in[PAY-1 -: USER_BITS] = user;
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign payload_in[PAY-1-USER_BITS-k*WIDTH -: WIDTH] = din[k*WIDTH +: WIDTH];
    end

    function automatic logic frame_bit(input logic [CW-1:0] idx, input logic [PAY-1:0] pv);
        int p;
        int r;
        int d;
        logic [PAY-1:0] sh;
        if (int'(idx) < SYNC_ZEROS) return 1'b0;
        if (int'(idx) == SYNC_ZEROS) return 1'b1;
        p = int'(idx) - SYNC_ZEROS - 1;
        r = p % 5;
        if (r == 0) return 1'b1;
        d  = (p / 5) * 4 + r - 1;
        sh = pv << d;
        return sh[PAY-1];
    endfunction

    assign edge_w = wordclock & ~wc_d;
    assign accept = edge_w && (state == IDLE || cnt == LAST);

    // The line register is one cycle behind the counter, so look one bit ahead.
    always_comb begin
        nbit = 1'b0;
        if (accept)
            nbit = frame_bit('0, payload_in);
        else if (state == SEND && cnt != LAST)
            nbit = frame_bit(cnt + 1'b1, shadow);
    end

    always_ff @(posedge mclk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            wc_d        <= 1'b1;
            lightpipe   <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            wc_d        <= wordclock;
            frame_start <= accept;
            lightpipe   <= (NRZI != 0) ? (lightpipe ^ nbit) : nbit;
            if (edge_w && !accept)
                overrun <= 1'b1;
            if (accept) begin
                shadow <= payload_in;
                cnt    <= '0;
                state  <= SEND;
                busy   <= 1'b1;
            end else if (state == SEND) begin
                if (cnt == LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
